// File: rtl/execute_unit_mc_if.sv
// Decode-side and memory-side handshake bundle for the execute stage.
interface execute_unit_mc_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;
  logic [1:0]      in_a_sel;
  logic            in_b_sel;
  logic [4:0]      in_rd;
  logic            in_regwrite;
  logic            in_branch;
  logic [2:0]      in_br_cond;
  logic            in_jump;
  logic            in_jalr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_store_data;
  logic [4:0]      out_rd;
  logic            out_regwrite;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            busy;

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_imm, in_pc, in_a_sel,
           in_b_sel, in_rd, in_regwrite, in_branch, in_br_cond, in_jump,
           in_jalr, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd,
           out_regwrite, out_taken, out_target, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_imm, in_pc, in_a_sel,
           in_b_sel, in_rd, in_regwrite, in_branch, in_br_cond, in_jump,
           in_jalr, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd,
           out_regwrite, out_taken, out_target, busy
  );
endinterface

// File: rtl/execute_unit_mc.sv
// Execute stage: one-cycle ALU/branch resolution plus a shared radix-2
// iterative multiply/divide unit for M-extension ops.
module execute_unit_mc #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  execute_unit_mc_if.slave  bus
);
  localparam int SH = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_PASSB = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,    OP_REMU = 5'd23;

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic [4:0]        m_op;
  logic              neg_q, neg_r, div_zero;

  logic              accept, is_mop, start_m, finish_m;
  logic [XLEN-1:0]   op_a, op_b, alu_result, single_result, target;
  logic [SH-1:0]     shamt;
  logic              eq, lt, ltu, cond, taken;
  logic              signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   m_result;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mop       = MULDIV_EN && (bus.in_op[4:3] == 2'b10);
  assign start_m      = accept && is_mop;
  assign finish_m     = (state == CALC) && (count == '0) && !bus.flush;
  assign bus.busy     = (state != IDLE);

  always_comb begin
    op_a = '0;
    case (bus.in_a_sel)
      2'b00:   op_a = bus.in_rs1;
      2'b01:   op_a = bus.in_pc;
      default: op_a = '0;
    endcase
    op_b  = bus.in_b_sel ? bus.in_imm : bus.in_rs2;
    shamt = op_b[SH-1:0];
    alu_result = '0;
    case (bus.in_op)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_SLL:   alu_result = op_a << shamt;
      OP_SLT:   alu_result = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU:  alu_result = XLEN'(op_a < op_b);
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_SRL:   alu_result = op_a >> shamt;
      OP_SRA:   alu_result = $signed(op_a) >>> shamt;
      OP_OR:    alu_result = op_a | op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_PASSB: alu_result = op_b;
      default:  alu_result = '0;
    endcase
  end

  always_comb begin
    eq   = (bus.in_rs1 == bus.in_rs2);
    lt   = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
    ltu  = (bus.in_rs1 < bus.in_rs2);
    cond = 1'b0;
    case (bus.in_br_cond)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
    taken  = bus.in_jump || (bus.in_branch && cond);
    target = bus.in_jalr ? ((bus.in_rs1 + bus.in_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                         : (bus.in_pc + bus.in_imm);
    single_result = bus.in_jump ? (bus.in_pc + XLEN'(4)) : alu_result;
  end

  // Operands are reduced to magnitudes; the sign is reapplied once at the end.
  always_comb begin
    signed_a = bus.in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed_b = bus.in_op inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = signed_a && bus.in_rs1[XLEN-1];
    b_neg    = signed_b && bus.in_rs2[XLEN-1];
    mag_a    = a_neg ? -bus.in_rs1 : bus.in_rs1;
    mag_b    = b_neg ? -bus.in_rs2 : bus.in_rs2;
  end

  // acc holds {product-high, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (m_op[2])
      acc_step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod     = neg_q ? -acc : acc;
    m_result = '0;
    case (m_op)
      OP_MUL:                       m_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: m_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              m_result = div_zero ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      OP_REM, OP_REMU:              m_result = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      default:                      m_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_m) state_next = CALC;
      CALC:    if (bus.flush || count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      m_op     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (start_m) begin
      count    <= CW'(XLEN);
      acc      <= {{XLEN{1'b0}}, mag_a};
      mcand    <= mag_b;
      m_op     <= bus.in_op;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (bus.in_rs2 == '0);
    end else if (state == CALC && count != '0) begin
      acc   <= acc_step;
      count <= count - 1'b1;
    end
  end

  // Side-band fields load at accept for every op; an M-op only fills result/valid when done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_result     <= '0;
      bus.out_store_data <= '0;
      bus.out_rd         <= '0;
      bus.out_regwrite   <= 1'b0;
      bus.out_taken      <= 1'b0;
      bus.out_target     <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.out_taken <= 1'b0;
    end else if (accept) begin
      bus.out_store_data <= bus.in_rs2;
      bus.out_rd         <= bus.in_rd;
      bus.out_regwrite   <= bus.in_regwrite;
      bus.out_taken      <= taken;
      bus.out_target     <= target;
      if (is_mop) begin
        bus.out_valid <= 1'b0;
      end else begin
        bus.out_result <= single_result;
        bus.out_valid  <= 1'b1;
      end
    end else if (finish_m) begin
      bus.out_result <= m_result;
      bus.out_valid  <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
